gerenciador_ativos: RTL
=======================

# gerenciador_ativos

Controller for the array of active-node cells in the path-search accelerator. Accepts update and removal requests keyed by node address, finds the cell that already holds the address (or the lowest free cell), and drives the shared cell control bus with a one-hot enable. Continuously reduces the cells' criteria to the global minimum fed back to every cell. Sits between the expansion/approval logic and the `NUM_SLOTS` active-node cells.

## Interface

**Parameters**
- `NUM_SLOTS`, default 8: number of active-node cells, at least 2.
- `ADDR_WIDTH`, default 5: node address width.
- `DISTANCIA_WIDTH`, default 5: accumulated distance width.
- `CRITERIO_WIDTH`, default 5: criterion width.
- `CUSTO_WIDTH`, default 4: neighbour cost width.

**Ports**

Clock and reset:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.

Request side:
- `upd_valid_in`, in, 1: update request.
- `upd_endereco_in`, in, `ADDR_WIDTH`: node address to update.
- `upd_distancia_in`, in, `DISTANCIA_WIDTH`: distance to update.
- `upd_anterior_in`, in, `ADDR_WIDTH`: predecessor to update.
- `upd_menor_vizinho_in`, in, `CUSTO_WIDTH`: smallest neighbour cost.
- `rem_valid_in`, in, 1: removal request.
- `rem_endereco_in`, in, `ADDR_WIDTH`: node address to remove.
- `ga_ready_out`, out, 1: high only in IDLE; a request is accepted when valid and ready are both high.

Cell status inputs (flattened; slot i uses bits `[i*W +: W]`):
- `na_ativo_in`, in, `NUM_SLOTS`: active flag per slot.
- `na_endereco_in`, in, `NUM_SLOTS*ADDR_WIDTH`: address per slot.
- `na_criterio_in`, in, `NUM_SLOTS*CRITERIO_WIDTH`: criterion per slot.

Cell control outputs (shared bus):
- `ga_habilitar_out`, out, `NUM_SLOTS`: one-hot slot enable.
- `ga_atualizar_out`, out, 1: update strobe.
- `ga_desativar_out`, out, 1: deactivate strobe.
- `ga_endereco_out`, out, `ADDR_WIDTH`: address broadcast to cells.
- `ga_distancia_out`, out, `DISTANCIA_WIDTH`: distance broadcast to cells.
- `ga_anterior_out`, out, `ADDR_WIDTH`: predecessor broadcast to cells.
- `ga_menor_vizinho_out`, out, `CUSTO_WIDTH`: neighbour cost broadcast to cells.
- `ga_criterio_geral_out`, out, `CRITERIO_WIDTH`: registered minimum of `na_criterio_in`.

Status:
- `ga_cheio_out`, out, 1: all slots active.
- `ga_vazio_out`, out, 1: no slot active.
- `ga_overflow_out`, out, 1: one-cycle pulse when an update is dropped.

## Operation

**FSM states**
- IDLE: `ga_ready_out`=1.
  - On accept, latch the request fields into holding registers and go to BUSCA.
  - `rem_valid_in` has priority over `upd_valid_in` when both are high; the update stays pending with valid held.
- BUSCA: compare the held address against every slot with `na_ativo_in`=1 and register the result.
  - The lowest-index match wins.
  - Without a match, take the lowest-index slot with `na_ativo_in`=0.
  - Go to EXEC.
- EXEC: drive the control bus for exactly one cycle, then go to ESPERA.
  - Update with a match: one-hot on the matched slot, `ga_atualizar_out`=1. The cell applies its own smaller-distance rule.
  - Update without a match, free slot found: one-hot on the free slot, `ga_atualizar_out`=1 (the cell activates).
  - Update without a match, array full: `ga_habilitar_out`=0, `ga_overflow_out`=1, request dropped.
  - Removal with a match: one-hot on the matched slot, `ga_desativar_out`=1.
  - Removal without a match: no enable, silent no-op.
- ESPERA: one cycle so cell registers settle before the next lookup; then go to IDLE.

**Bus and status outputs**
- The broadcast data buses (`ga_endereco_out`, `ga_distancia_out`, `ga_anterior_out`, `ga_menor_vizinho_out`) hold the latched request from BUSCA through ESPERA.
- `ga_habilitar_out`, `ga_atualizar_out` and `ga_desativar_out` are 0 outside EXEC.
- `ga_criterio_geral_out` is the registered unsigned minimum over all slots, updated every cycle.
  - Inactive cells present all-ones, so an empty array yields all-ones.
  - The minimum is computed at `CRITERIO_WIDTH`, with no widening.
- `ga_cheio_out` and `ga_vazio_out` are registered from `na_ativo_in`.

**Reset**
- Async reset forces IDLE from any state. A request in flight is discarded and no enable is issued.
- Reset values:
  - all control outputs, data buses and `ga_overflow_out` are 0;
  - `ga_criterio_geral_out` is all-ones;
  - `ga_vazio_out`=1 and `ga_cheio_out`=0.

## Timing

- An accept at edge T gives BUSCA in T+1, EXEC pulse in T+2, ESPERA in T+3, and `ga_ready_out`=1 again in T+4.
- Throughput is one request per 4 cycles.
- `ga_criterio_geral_out` lags `na_criterio_in` by 1 cycle. Cells add one more cycle on top of that, so a cell change at EXEC is visible on the minimum 2 cycles after EXEC.
- Flags lag `na_ativo_in` by 1 cycle.

## Structure

- Shared package `ga_pkg`:
  - the FSM state encoding (IDLE=0, BUSCA=1, EXEC=2, ESPERA=3);
  - the all-ones criterion constant.
- One sub-module, `ga_arvore_minimo`: parameterised, registered output, `NUM_SLOTS` not required to be a power of two. It is reusable for the approval path.
- Match and free-slot priority encoders stay inline.

## Test plan

- Reset, then update addr=3, dist=7, slots empty → one-hot 0b0000_0001 with `ga_atualizar_out` at T+2; `ga_vazio_out` falls after the cell activates.
- Slot 0 holds addr=3, then update addr=3, dist=4 → enable on slot 0 only, not on free slot 1.
- Fill all 8 slots, then update addr=20 → no enable, `ga_overflow_out` pulse at T+2, `ga_cheio_out`=1.
- `rem_valid_in` and `upd_valid_in` asserted together → removal served first; update accepted at T+4; the removed slot becomes the free slot for that update if the address is new.
- Slot criteria 9, 5 and 12, rest inactive → `ga_criterio_geral_out`=5; deactivate slot 1 → becomes 9; all inactive → 31.
- `rst_n` asserted during BUSCA → outputs at reset values immediately; no enable pulse; `ga_ready_out`=1 after release.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared types and constants for the active-node array controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ga_pkg;

  // Controller sequence: accept, search, drive the cell bus, settle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSCA  = 2'd1,
    EXEC   = 2'd2,
    ESPERA = 2'd3
  } ga_estado_t;

  // Criterion that an inactive cell presents; consumers slice it to their width.
  localparam int                            CRITERIO_MAX_WIDTH = 32;
  localparam logic [CRITERIO_MAX_WIDTH-1:0] CRITERIO_INFINITO  = '1;

endpackage

// File: rtl/ga_arvore_minimo.sv
// Registered unsigned minimum over a flat vector of NUM_ENTRADAS values.
// Latency: 1 cycle from i_valores to o_minimo.
// Backpressure: none; recomputed every cycle.
// Ports: clk/rst_n (async, active-low); i_valores = NUM_ENTRADAS packed values
//        of LARGURA bits (entry i at [i*LARGURA +: LARGURA]); o_minimo = minimum,
//        all-ones while in reset.
module ga_arvore_minimo
  import ga_pkg::*;
#(
  parameter int NUM_ENTRADAS = 8,
  parameter int LARGURA      = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_ENTRADAS*LARGURA-1:0] i_valores,
  output logic [LARGURA-1:0]              o_minimo
);

  localparam logic [LARGURA-1:0] INFINITO = CRITERIO_INFINITO[LARGURA-1:0];

  logic [LARGURA-1:0] w_minimo;
  logic [LARGURA-1:0] r_minimo;

  // Reduction starts from all-ones, so any entry count works (no padding to
  // a power of two) and an all-inactive input yields all-ones.
  always_comb begin
    w_minimo = INFINITO;
    for (int i = 0; i < NUM_ENTRADAS; i++) begin
      if (i_valores[i*LARGURA +: LARGURA] < w_minimo) begin
        w_minimo = i_valores[i*LARGURA +: LARGURA];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minimo <= INFINITO;
    end else begin
      r_minimo <= w_minimo;
    end
  end

  assign o_minimo = r_minimo;

endmodule

// File: rtl/gerenciador_ativos.sv
// Active-node cell controller: looks up an address in the cell array and drives one cell per request.
// Latency: accept -> BUSCA +1, EXEC strobe +2, ready again +4 cycles; one request per 4 cycles.
// Backpressure: ga_ready_out is high only in IDLE; removal wins over update when both are valid.
// Ports: upd_* / rem_* request side (valid/ready); na_* flattened cell status (slot i at [i*W +: W]);
//        ga_* shared cell control bus, registered global criterion minimum, full/empty flags,
//        one-cycle overflow pulse when an update finds neither a match nor a free slot.
module gerenciador_ativos
  import ga_pkg::*;
#(
  parameter int NUM_SLOTS       = 8,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CRITERIO_WIDTH  = 5,
  parameter int CUSTO_WIDTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                upd_valid_in,
  input  logic [ADDR_WIDTH-1:0]               upd_endereco_in,
  input  logic [DISTANCIA_WIDTH-1:0]          upd_distancia_in,
  input  logic [ADDR_WIDTH-1:0]               upd_anterior_in,
  input  logic [CUSTO_WIDTH-1:0]              upd_menor_vizinho_in,
  input  logic                                rem_valid_in,
  input  logic [ADDR_WIDTH-1:0]               rem_endereco_in,
  output logic                                ga_ready_out,
  input  logic [NUM_SLOTS-1:0]                na_ativo_in,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]     na_endereco_in,
  input  logic [NUM_SLOTS*CRITERIO_WIDTH-1:0] na_criterio_in,
  output logic [NUM_SLOTS-1:0]                ga_habilitar_out,
  output logic                                ga_atualizar_out,
  output logic                                ga_desativar_out,
  output logic [ADDR_WIDTH-1:0]               ga_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]          ga_distancia_out,
  output logic [ADDR_WIDTH-1:0]               ga_anterior_out,
  output logic [CUSTO_WIDTH-1:0]              ga_menor_vizinho_out,
  output logic [CRITERIO_WIDTH-1:0]           ga_criterio_geral_out,
  output logic                                ga_cheio_out,
  output logic                                ga_vazio_out,
  output logic                                ga_overflow_out
);

  localparam logic [NUM_SLOTS-1:0] UM = NUM_SLOTS'(1);

  ga_estado_t r_estado;
  ga_estado_t w_proximo;

  logic                       w_aceita;
  logic                       r_remocao;
  logic [ADDR_WIDTH-1:0]      r_endereco;
  logic [DISTANCIA_WIDTH-1:0] r_distancia;
  logic [ADDR_WIDTH-1:0]      r_anterior;
  logic [CUSTO_WIDTH-1:0]     r_menor_vizinho;

  logic [NUM_SLOTS-1:0] w_iguais;
  logic [NUM_SLOTS-1:0] w_livres;
  logic [NUM_SLOTS-1:0] w_prim_igual;
  logic [NUM_SLOTS-1:0] w_prim_livre;
  logic                 r_achou;
  logic                 r_livre;
  logic [NUM_SLOTS-1:0] r_sel_achou;
  logic [NUM_SLOTS-1:0] r_sel_livre;

  logic r_cheio;
  logic r_vazio;

  assign w_aceita = (r_estado == IDLE) && (rem_valid_in || upd_valid_in);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Next-state logic
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      IDLE:    if (w_aceita) w_proximo = BUSCA;
      BUSCA:   w_proximo = EXEC;
      EXEC:    w_proximo = ESPERA;
      ESPERA:  w_proximo = IDLE;
      default: w_proximo = IDLE;
    endcase
  end

  // Request holding registers; a removal carries only its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remocao       <= 1'b0;
      r_endereco      <= '0;
      r_distancia     <= '0;
      r_anterior      <= '0;
      r_menor_vizinho <= '0;
    end else if (w_aceita) begin
      r_remocao <= rem_valid_in;
      if (rem_valid_in) begin
        r_endereco      <= rem_endereco_in;
        r_distancia     <= '0;
        r_anterior      <= '0;
        r_menor_vizinho <= '0;
      end else begin
        r_endereco      <= upd_endereco_in;
        r_distancia     <= upd_distancia_in;
        r_anterior      <= upd_anterior_in;
        r_menor_vizinho <= upd_menor_vizinho_in;
      end
    end
  end

  // Address match only counts on active cells; stale addresses in free cells are ignored.
  always_comb begin
    w_iguais = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_iguais[i] = na_ativo_in[i] && (na_endereco_in[i*ADDR_WIDTH +: ADDR_WIDTH] == r_endereco);
    end
  end

  assign w_livres = ~na_ativo_in;

  // x & -x isolates the lowest set bit: lowest-index priority as a one-hot.
  assign w_prim_igual = w_iguais & (~w_iguais + UM);
  assign w_prim_livre = w_livres & (~w_livres + UM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_achou     <= 1'b0;
      r_livre     <= 1'b0;
      r_sel_achou <= '0;
      r_sel_livre <= '0;
    end else if (r_estado == BUSCA) begin
      r_achou     <= |w_iguais;
      r_livre     <= |w_livres;
      r_sel_achou <= w_prim_igual;
      r_sel_livre <= w_prim_livre;
    end
  end

  // Output logic: control strobes exist only in EXEC.
  always_comb begin
    ga_ready_out     = 1'b0;
    ga_habilitar_out = '0;
    ga_atualizar_out = 1'b0;
    ga_desativar_out = 1'b0;
    ga_overflow_out  = 1'b0;
    case (r_estado)
      IDLE: ga_ready_out = 1'b1;
      EXEC: begin
        if (r_remocao) begin
          if (r_achou) begin
            ga_habilitar_out = r_sel_achou;
            ga_desativar_out = 1'b1;
          end
        end else if (r_achou) begin
          ga_habilitar_out = r_sel_achou;
          ga_atualizar_out = 1'b1;
        end else if (r_livre) begin
          ga_habilitar_out = r_sel_livre;
          ga_atualizar_out = 1'b1;
        end else begin
          ga_overflow_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Broadcast buses carry the held request from BUSCA through ESPERA only.
  assign ga_endereco_out      = (r_estado == IDLE) ? '0 : r_endereco;
  assign ga_distancia_out     = (r_estado == IDLE) ? '0 : r_distancia;
  assign ga_anterior_out      = (r_estado == IDLE) ? '0 : r_anterior;
  assign ga_menor_vizinho_out = (r_estado == IDLE) ? '0 : r_menor_vizinho;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cheio <= 1'b0;
      r_vazio <= 1'b1;
    end else begin
      r_cheio <= &na_ativo_in;
      r_vazio <= ~|na_ativo_in;
    end
  end

  assign ga_cheio_out = r_cheio;
  assign ga_vazio_out = r_vazio;

  ga_arvore_minimo #(
    .NUM_ENTRADAS (NUM_SLOTS),
    .LARGURA      (CRITERIO_WIDTH)
  ) u_minimo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valores (na_criterio_in),
    .o_minimo  (ga_criterio_geral_out)
  );

endmodule
